// File: rtl/vdp1_cmd_fetch.sv
// rtl/vdp1_cmd_fetch.sv - VDP1 command-table list walker: fetches 15 words per table, issues commands, follows links
module vdp1_cmd_fetch (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         START,
  input  logic         STOP,
  output logic [17:0]  VRAM_A,
  output logic         VRAM_RD,
  input  logic [15:0]  VRAM_D,
  input  logic         VRAM_RDY,
  output logic [255:0] CMD,
  output logic         CMD_VALID,
  input  logic         CMD_READY,
  output logic         BUSY,
  output logic         END_PULSE,
  output logic [15:0]  COPR,
  output logic [15:0]  LOPR
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, ISSUE, NEXT} state_t;

  state_t         state_q, state_d;
  logic [15:0]    tp_q, tp_d;
  logic [15:0]    ret_q, ret_d;
  logic [15:0]    lopr_q, lopr_d;
  logic           call_q, call_d;
  logic           end_q, end_d;
  logic [3:0]     idx_q, idx_d;
  logic [255:0]   cmd_q, cmd_d;

  logic [15:0]    word_mask;
  logic [15:0]    word_in;
  logic [15:0]    nxt_tp;
  logic [15:0]    lnk_tp;
  logic [2:0]     jp;
  logic [7:0]     slot_lsb;

  // Word 0 (CTRL) and word 1 (LINK) are already held in cmd_q when the walk decision is made
  assign jp       = cmd_q[254:252];
  assign lnk_tp   = cmd_q[239:224];
  assign nxt_tp   = tp_q + 16'd4;
  assign word_in  = VRAM_D & word_mask;
  assign slot_lsb = {4'd15 - idx_q, 4'd0};

  always_comb begin
    case (idx_q)
      4'd0:    word_mask = 16'hFF3F;
      4'd1:    word_mask = 16'hFFFC;
      4'd2:    word_mask = 16'h9FFF;
      4'd5:    word_mask = 16'h3FFF;
      default: word_mask = 16'hFFFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    ret_d   = ret_q;
    lopr_d  = lopr_q;
    call_d  = call_q;
    end_d   = end_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    if (CE) begin
      end_d = 1'b0;
      if (STOP) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (START) begin
              tp_d    = 16'd0;
              call_d  = 1'b0;
              idx_d   = 4'd0;
              state_d = RD_REQ;
            end
          end
          RD_REQ, RD_WAIT: begin
            if (VRAM_RDY) begin
              cmd_d[slot_lsb +: 16] = word_in;
              if (idx_q == 4'd0 && word_in[15]) begin
                lopr_d  = tp_q;
                end_d   = 1'b1;
                state_d = IDLE;
              end else if (idx_q == 4'd14) begin
                state_d = jp[2] ? NEXT : ISSUE;
              end else begin
                idx_d   = idx_q + 4'd1;
                state_d = RD_REQ;
              end
            end else begin
              state_d = RD_WAIT;
            end
          end
          ISSUE: begin
            if (CMD_READY) state_d = NEXT;
          end
          NEXT: begin
            case (jp[1:0])
              2'd0: tp_d = nxt_tp;
              2'd1: tp_d = lnk_tp;
              2'd2: begin
                ret_d  = nxt_tp;
                call_d = 1'b1;
                tp_d   = lnk_tp;
              end
              default: begin
                if (call_q) begin
                  tp_d   = ret_q;
                  call_d = 1'b0;
                end else begin
                  tp_d   = nxt_tp;
                end
              end
            endcase
            idx_d   = 4'd0;
            state_d = RD_REQ;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tp_q    <= 16'd0;
      ret_q   <= 16'd0;
      lopr_q  <= 16'd0;
      call_q  <= 1'b0;
      end_q   <= 1'b0;
      idx_q   <= 4'd0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      ret_q   <= ret_d;
      lopr_q  <= lopr_d;
      call_q  <= call_d;
      end_q   <= end_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
    end
  end

  // Word 1E is never fetched, so cmd_q[15:0] keeps its reset value of zero
  assign VRAM_A    = {tp_q, 2'b00} + {14'd0, idx_q};
  assign VRAM_RD   = (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign CMD       = cmd_q;
  assign CMD_VALID = (state_q == ISSUE);
  assign BUSY      = (state_q != IDLE);
  assign END_PULSE = end_q;
  assign COPR      = tp_q;
  assign LOPR      = lopr_q;

endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// tb/tb_vdp1_cmd_fetch.sv - randomized self-checking bench for vdp1_cmd_fetch against a list-walk model
module tb_vdp1_cmd_fetch;

  logic         CLK = 1'b0;
  logic         RST, CE, START, STOP;
  logic [17:0]  VRAM_A;
  logic         VRAM_RD;
  logic [15:0]  VRAM_D;
  logic         VRAM_RDY;
  logic [255:0] CMD;
  logic         CMD_VALID, CMD_READY;
  logic         BUSY, END_PULSE;
  logic [15:0]  COPR, LOPR;

  vdp1_cmd_fetch dut (
    .CLK(CLK), .RST(RST), .CE(CE), .START(START), .STOP(STOP),
    .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_D(VRAM_D), .VRAM_RDY(VRAM_RDY),
    .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .BUSY(BUSY), .END_PULSE(END_PULSE), .COPR(COPR), .LOPR(LOPR)
  );

  always #5 CLK = ~CLK;

  logic [15:0]  mem [0:4095];
  logic [17:0]  exp_addr[$];
  logic [15:0]  exp_tp[$];
  logic [255:0] exp_cmd[$];
  bit           exp_end;
  logic [15:0]  model_lopr, model_tp_final;

  int n_cmp = 0;
  int n_fail = 0;
  int reads_seen, cmds_seen, end_seen;
  bit chk_en = 1'b0;

  bit           prev_rd, prev_acc, prev_valid, prev_xfer, prev_ce, prev_stop;
  logic [17:0]  prev_a;
  logic [255:0] prev_cmd;

  task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] word_mask(input int i);
    case (i)
      0:       return 16'hFF3F;
      1:       return 16'hFFFC;
      2:       return 16'h9FFF;
      5:       return 16'h3FFF;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Software walk of the list held in mem: expected reads, issued commands and end result
  task automatic model_walk(input int max_tables);
    logic [15:0]  tp, ret, nxt, lnk;
    logic [15:0]  w [0:15];
    logic [255:0] c;
    logic [17:0]  a;
    logic [2:0]   jpv;
    bit           cv;
    exp_addr.delete(); exp_tp.delete(); exp_cmd.delete();
    exp_end = 1'b0;
    tp = 16'd0; ret = 16'd0; cv = 1'b0;
    for (int t = 0; t < max_tables; t++) begin
      for (int i = 0; i < 16; i++) w[i] = 16'd0;
      for (int i = 0; i < 15; i++) begin
        a = {tp, 2'b00} + 18'(i);
        exp_addr.push_back(a);
        exp_tp.push_back(tp);
        w[i] = mem[a[11:0]] & word_mask(i);
        if (i == 0 && w[0][15]) begin
          exp_end = 1'b1;
          model_lopr = tp;
          model_tp_final = tp;
          return;
        end
      end
      c = '0;
      for (int i = 0; i < 16; i++) c[255-16*i -: 16] = w[i];
      jpv = w[0][14:12];
      if (!jpv[2]) exp_cmd.push_back(c);
      nxt = tp + 16'd4;
      lnk = w[1];
      case (jpv[1:0])
        2'd0: tp = nxt;
        2'd1: tp = lnk;
        2'd2: begin ret = nxt; cv = 1'b1; tp = lnk; end
        default: begin
          if (cv) begin tp = ret; cv = 1'b0; end
          else tp = nxt;
        end
      endcase
    end
    model_tp_final = tp;
  endtask

  always @(negedge CLK) begin
    bit acc, xfer;
    if (chk_en) begin
      acc  = VRAM_RD && VRAM_RDY && CE && !STOP;
      xfer = CMD_VALID && CMD_READY && CE && !STOP;
      if (prev_ce && prev_stop) begin
        check_eq("stop_busy", BUSY, 0);
        check_eq("stop_rd", VRAM_RD, 0);
        check_eq("stop_valid", CMD_VALID, 0);
        check_eq("stop_end", END_PULSE, 0);
      end else begin
        if (prev_rd && !prev_acc) begin
          check_eq("rd_held", VRAM_RD, 1);
          check_eq("addr_stable", VRAM_A, prev_a);
        end
        if (prev_valid && !prev_xfer) begin
          check_eq("valid_held", CMD_VALID, 1);
          check_eq("cmd_stable", CMD, prev_cmd);
        end
      end
      if (acc) begin
        reads_seen++;
        if (exp_addr.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra_read: got read at %0h want no read", VRAM_A);
        end else begin
          check_eq("read_addr", VRAM_A, exp_addr.pop_front());
          check_eq("copr", COPR, exp_tp.pop_front());
        end
      end
      if (xfer) begin
        cmds_seen++;
        check_eq("cmd_w02_low", CMD[225:224], 0);
        check_eq("cmd_w1e", CMD[15:0], 0);
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra_cmd: got %0h want no command", CMD);
        end else begin
          check_eq("cmd", CMD, exp_cmd.pop_front());
        end
      end
      if (END_PULSE && CE) begin
        end_seen++;
        check_eq("lopr_at_end", LOPR, model_lopr);
      end
      prev_rd = VRAM_RD; prev_acc = acc; prev_a = VRAM_A;
      prev_valid = CMD_VALID; prev_xfer = xfer; prev_cmd = CMD;
      prev_ce = CE; prev_stop = STOP;
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b1; CE = 1'($urandom_range(0, 1)); START = 1'b1; STOP = 1'b1;
    VRAM_RDY = 1'b1; CMD_READY = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b0; CE = 1'b1; START = 1'b0; STOP = 1'b0; VRAM_RDY = 1'b0;
    model_lopr = 16'd0;
    prev_rd = 0; prev_acc = 0; prev_valid = 0; prev_xfer = 0; prev_ce = 0; prev_stop = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_addr"}, VRAM_A, 0);
    check_eq({tag, "_rd"}, VRAM_RD, 0);
    check_eq({tag, "_cmd"}, CMD, 0);
    check_eq({tag, "_valid"}, CMD_VALID, 0);
    check_eq({tag, "_busy"}, BUSY, 0);
    check_eq({tag, "_end"}, END_PULSE, 0);
    check_eq({tag, "_copr"}, COPR, 0);
    check_eq({tag, "_lopr"}, LOPR, 0);
  endtask

  task automatic run_walk(input bit ce_rand, input int max_dly, input int ready_hold, input bit extra_start);
    int dly, vcnt, cyc;
    bit stopping, done;
    reads_seen = 0; cmds_seen = 0; end_seen = 0;
    dly = $urandom_range(0, max_dly); vcnt = 0; cyc = 0;
    stopping = 1'b0; done = 1'b0;
    chk_en = 1'b1;
    while (!done && cyc < 20000) begin
      @(posedge CLK); #2;
      cyc++;
      if (stopping || (exp_end && end_seen > 0 && !BUSY)) begin
        done = 1'b1;
        START = 1'b0; STOP = 1'b0; VRAM_RDY = 1'b0; CE = 1'b1; CMD_READY = 1'b0;
      end else begin
        CE = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        START = 1'b0; STOP = 1'b0;
        if (cyc == 1) begin
          START = 1'b1; CE = 1'b1;
        end else if (extra_start && BUSY && $urandom_range(0, 15) == 0) begin
          START = 1'b1;
        end
        if (!exp_end && exp_addr.size() == 0 && exp_cmd.size() == 0 && VRAM_RD && cyc > 1) begin
          STOP = 1'b1; CE = 1'b1; START = 1'($urandom_range(0, 1));
          stopping = 1'b1;
        end
        if (VRAM_RD) begin
          if (exp_addr.size() > 0 && dly == 0) begin
            VRAM_RDY = 1'b1; VRAM_D = mem[VRAM_A[11:0]];
          end else begin
            VRAM_RDY = stopping; VRAM_D = 16'($urandom);
            if (dly > 0) dly--;
          end
        end else begin
          VRAM_RDY = 1'($urandom_range(0, 1)); VRAM_D = 16'($urandom);
        end
        if (VRAM_RD && VRAM_RDY && CE && !STOP) dly = $urandom_range(0, max_dly);
        if (CMD_VALID) vcnt++; else vcnt = 0;
        CMD_READY = (ready_hold < 0) ? 1'($urandom_range(0, 2) != 0) : (vcnt > ready_hold);
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL walk_timeout: got %0d cycles want completion", cyc);
    end
    @(negedge CLK); #1;
    chk_en = 1'b0;
    check_eq("reads_left", exp_addr.size(), 0);
    check_eq("cmds_left", exp_cmd.size(), 0);
    check_eq("end_count", end_seen, exp_end);
    check_eq("lopr_final", LOPR, model_lopr);
    check_eq("copr_final", COPR, model_tp_final);
    check_eq("busy_final", BUSY, 0);
    check_eq("valid_final", CMD_VALID, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] ctrl;
    RST = 1'b1; CE = 1'b0; START = 1'b0; STOP = 1'b0;
    VRAM_D = 16'd0; VRAM_RDY = 1'b0; CMD_READY = 1'b0;
    repeat (2) @(posedge CLK);
    do_reset();
    @(negedge CLK); #1;
    check_reset_state("rst0");

    // single END table at TP 0
    fill_random(); mem[0] = 16'h8000;
    do_reset(); model_walk(8);
    check_eq("m25_reads", exp_addr.size(), 1);
    check_eq("m25_end", exp_end, 1);
    run_walk(1'b0, 3, -1, 1'b0);
    check_eq("t25_reads", reads_seen, 1);
    check_eq("t25_cmds", cmds_seen, 0);
    check_eq("t25_lopr", LOPR, 16'h0000);

    // one command then END, ready held off 10 cycles
    fill_random(); mem[0] = 16'h0004; mem[1] = 16'h0000; mem[16'h10] = 16'h8000;
    do_reset(); model_walk(8);
    check_eq("m26_reads", exp_addr.size(), 16);
    check_eq("m26_cmds", exp_cmd.size(), 1);
    check_eq("m26_w00", exp_cmd[0][255:240], 16'h0004);
    check_eq("m26_a15", exp_addr[15], 18'h10);
    run_walk(1'b0, 2, 10, 1'b0);
    check_eq("t26_cmds", cmds_seen, 1);
    check_eq("t26_lopr", LOPR, 16'h0004);

    // reset mid-issue without a prior reset: state from previous walk is live
    chk_en = 1'b0; n = 0;
    @(posedge CLK); #2; START = 1'b1; CE = 1'b1; CMD_READY = 1'b0; VRAM_RDY = 1'b0;
    while (!CMD_VALID && n < 200) begin
      @(posedge CLK); #2; START = 1'b0;
      VRAM_RDY = VRAM_RD; VRAM_D = mem[VRAM_A[11:0]]; n++;
    end
    check_eq("issue_reached", CMD_VALID, 1);
    check_eq("issue_w00", CMD[255:240], 16'h0004);
    RST = 1'b1; CE = 1'b0; STOP = 1'b1; START = 1'b1; CMD_READY = 1'b1; VRAM_RDY = 1'b1;
    @(posedge CLK); #2;
    RST = 1'b0; STOP = 1'b0; START = 1'b0; CE = 1'b1;
    @(negedge CLK); #1;
    check_reset_state("rst_issue");
    repeat (3) begin
      @(negedge CLK); #1;
      check_eq("late_rdy_busy", BUSY, 0);
      check_eq("late_rdy_rd", VRAM_RD, 0);
    end

    // call / return
    fill_random(); mem[0] = 16'h2004; mem[1] = 16'h0040;
    mem[16'h100] = 16'h3004; mem[16'h10] = 16'h8000;
    do_reset(); model_walk(8);
    check_eq("m27_reads", exp_addr.size(), 31);
    check_eq("m27_a15", exp_addr[15], 18'h100);
    check_eq("m27_a30", exp_addr[30], 18'h10);
    check_eq("m27_cmds", exp_cmd.size(), 2);
    run_walk(1'b0, 3, -1, 1'b1);
    check_eq("t27_cmds", cmds_seen, 2);
    check_eq("t27_lopr", LOPR, 16'h0004);

    // skipped command
    fill_random(); mem[0] = 16'h4004; mem[16'h10] = 16'h8000;
    do_reset(); model_walk(8);
    check_eq("m28_reads", exp_addr.size(), 16);
    check_eq("m28_cmds", exp_cmd.size(), 0);
    check_eq("m28_a15", exp_addr[15], 18'h10);
    run_walk(1'b1, 4, -1, 1'b0);
    check_eq("t28_cmds", cmds_seen, 0);

    // jump to 0xFFFC, wrap back to 0, endless list stopped mid-read
    fill_random(); mem[0] = 16'h1000; mem[1] = 16'hFFFC; mem[12'hFF0] = 16'h0000;
    do_reset(); model_walk(3);
    check_eq("mw_a15", exp_addr[15], 18'h3FFF0);
    check_eq("mw_a30", exp_addr[30], 18'h0);
    check_eq("mw_cmds", exp_cmd.size(), 3);
    run_walk(1'b0, 2, -1, 1'b0);
    check_eq("tw_copr", COPR, 16'hFFFC);

    // random lists, random RDY latency, CE toggling
    for (int r = 0; r < 5; r++) begin
      fill_random();
      for (int t = 0; t < 64; t++) begin
        ctrl = 16'($urandom);
        ctrl[15] = ($urandom_range(0, 5) == 0);
        mem[t*16] = ctrl;
        mem[t*16+1] = 16'($urandom) & 16'h00FC;
      end
      do_reset(); model_walk(12);
      run_walk(1'b1, 7, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
